hazard_stall_controller: RTL

Parametrised load-use hazard and stall controller for the ID stage of the 5-stage pipeline. It detects load-use hazards between the IF/ID instruction and a load in ID/EX, and holds the PC and IF/ID register for a configurable number of bubble cycles. It also freezes the front end on an external memory-busy request, flushes IF/ID on a taken branch, and keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_stall_controller.sv | 112 +++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Load-use hazard and stall controller for the ID stage: inserts bubbles for
// loads feeding the next instruction, freezes on memory busy, flushes on branches.
module hazard_stall_controller #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int ZERO_REG_EXEMPT   = 1,
    parameter int PERF_W            = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ID_EX_MemRead,
    input  logic [REG_ADDR_W-1:0] ID_EX_RegisterRt,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_ADDR_W-1:0] IF_ID_RegisterRt,
    input  logic                  IF_ID_UsesRs,
    input  logic                  IF_ID_UsesRt,
    input  logic                  branch_taken,
    input  logic                  mem_busy,
    input  logic                  perf_clr,
    output logic                  PCWrite,
    output logic                  IF_ID_Write,
    output logic                  stall_mux,
    output logic                  IF_ID_Flush,
    output logic                  pipe_freeze,
    output logic                  stall_active,
    output logic [PERF_W-1:0]     stall_cycles
);

    localparam int REM_W = $clog2(LOAD_STALL_CYCLES + 1);

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

    state_t            state_q, state_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [PERF_W-1:0] stallCycles_q, stallCycles_d;

    logic rsMatch;
    logic rtMatch;
    logic zeroOk;
    logic haz;
    logic bubble;

    assign rsMatch = IF_ID_UsesRs && (ID_EX_RegisterRt == IF_ID_RegisterRs);
    assign rtMatch = IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt);
    assign zeroOk  = (ZERO_REG_EXEMPT == 0) || (ID_EX_RegisterRt != '0);
    assign haz     = ID_EX_MemRead && (rsMatch || rtMatch) && zeroOk;
    // Once in LOAD_STALL the bubble continues regardless of what now sits in ID/EX.
    assign bubble  = (state_q == LOAD_STALL) || haz;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        stallCycles_d = stallCycles_q;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        stall_mux     = 1'b1;
        IF_ID_Flush   = 1'b0;
        pipe_freeze   = 1'b0;
        stall_active  = 1'b0;

        if (!reset) begin
            if (mem_busy) begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                pipe_freeze = 1'b1;
            end else if (bubble) begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                stall_mux    = 1'b0;
                stall_active = 1'b1;
                if (stallCycles_q != '1) begin
                    stallCycles_d = stallCycles_q + 1'b1;
                end
                if (state_q == IDLE) begin
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LOAD_STALL;
                        rem_d   = REM_W'(LOAD_STALL_CYCLES - 1);
                    end
                end else begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == REM_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end else begin
                IF_ID_Flush = branch_taken;
            end

            if (perf_clr) begin
                stallCycles_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            stallCycles_q <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            stallCycles_q <= stallCycles_d;
        end
    end

    assign stall_cycles = stallCycles_q;

endmodule
